// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8-subset multicycle control sequencer:
// state encoding, opcode match values/masks, ALU operation encoding and
// the instruction class enum used between the opcode decoder and the FSM.
package legv8_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPC_W    = 11;
    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned STATE_W  = 3;

    // Sequencer states
    typedef logic [STATE_W-1:0] state_t;
    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_HALT   = 3'd5;

    // Full-width opcode values
    localparam logic [OPC_W-1:0] OPC_ADD  = 11'h458;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'h658;
    localparam logic [OPC_W-1:0] OPC_AND  = 11'h450;
    localparam logic [OPC_W-1:0] OPC_ORR  = 11'h550;
    localparam logic [OPC_W-1:0] OPC_LDUR = 11'h7C2;
    localparam logic [OPC_W-1:0] OPC_STUR = 11'h7C0;
    localparam logic [OPC_W-1:0] OPC_HALT = 11'h7FF;

    // Short opcodes: B uses opcode[10:5], CBZ uses opcode[10:3]
    localparam logic [OPC_W-1:0] B_MASK    = 11'h7E0;
    localparam logic [OPC_W-1:0] B_MATCH   = 11'h0A0;
    localparam logic [OPC_W-1:0] CBZ_MASK  = 11'h7F8;
    localparam logic [OPC_W-1:0] CBZ_MATCH = 11'h5A0;

    // ALU operation encoding
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 2'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 2'd1;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 2'd2;
    localparam logic [ALU_OP_W-1:0] ALU_ORR = 2'd3;

    typedef enum logic [2:0] {
        CLS_R    = 3'd0,
        CLS_LD   = 3'd1,
        CLS_ST   = 3'd2,
        CLS_B    = 3'd3,
        CLS_CBZ  = 3'd4,
        CLS_HALT = 3'd5,
        CLS_ILL  = 3'd6
    } instr_class_e;

endpackage

// File: rtl/legv8_opdecode.sv
// Combinational opcode classifier.
//   opcode        : 11-bit opcode from the field parser
//   instr_class_c : instruction class (ILL for anything unrecognised)
//   alu_op_c      : ALU operation for R-type; ADD for all other classes
module legv8_opdecode
    import legv8_pkg::*;
(
    input  logic [OPC_W-1:0]    opcode,
    output instr_class_e        instr_class_c,
    output logic [ALU_OP_W-1:0] alu_op_c
);

    // Classify opcode; exact matches first, then masked short opcodes
    always_comb begin
        instr_class_c = CLS_ILL;
        alu_op_c      = ALU_ADD;
        if (opcode == OPC_ADD) begin
            instr_class_c = CLS_R;
            alu_op_c      = ALU_ADD;
        end else if (opcode == OPC_SUB) begin
            instr_class_c = CLS_R;
            alu_op_c      = ALU_SUB;
        end else if (opcode == OPC_AND) begin
            instr_class_c = CLS_R;
            alu_op_c      = ALU_AND;
        end else if (opcode == OPC_ORR) begin
            instr_class_c = CLS_R;
            alu_op_c      = ALU_ORR;
        end else if (opcode == OPC_LDUR) begin
            instr_class_c = CLS_LD;
        end else if (opcode == OPC_STUR) begin
            instr_class_c = CLS_ST;
        end else if (opcode == OPC_HALT) begin
            instr_class_c = CLS_HALT;
        end else if ((opcode & B_MASK) == B_MATCH) begin
            instr_class_c = CLS_B;
        end else if ((opcode & CBZ_MASK) == CBZ_MATCH) begin
            instr_class_c = CLS_CBZ;
        end
    end

endmodule

// File: rtl/legv8_mc_ctrl.sv
// Multicycle control sequencer: fetches into ir, steps the decoded opcode
// through DECODE/EXEC/MEM/WB, drives ALU/regfile/dmem controls, owns the PC.
//   clk, rst_n                        : clock, async active-low reset
//   imem_req/imem_addr/imem_valid/imem_rdata : instruction fetch handshake
//   ir, opcode                        : instruction register out, parsed opcode in
//   alu_zero, alu_op, alu_src_imm     : ALU flag in, ALU controls out
//   reg_we, wb_sel_mem                : register-file write controls
//   dmem_req, dmem_we, dmem_ready     : data-memory handshake
//   pc, halted, illegal               : program counter and sticky status
module legv8_mc_ctrl
    import legv8_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_W-1:0]     imem_addr,
    input  logic                imem_valid,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic [INSTR_W-1:0]  ir,
    input  logic [OPC_W-1:0]    opcode,
    input  logic                alu_zero,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src_imm,
    output logic                reg_we,
    output logic                wb_sel_mem,
    output logic                dmem_req,
    output logic                dmem_we,
    input  logic                dmem_ready,
    output logic [PC_W-1:0]     pc,
    output logic                halted,
    output logic                illegal
);

    state_t              state_q, state_d;
    instr_class_e        cls_q, cls_d;
    instr_class_e        dec_cls_c;
    logic [ALU_OP_W-1:0] dec_alu_c;

    logic [PC_W-1:0]     pc_d;
    logic [INSTR_W-1:0]  ir_d;
    logic                halted_d, illegal_d;
    logic                imem_req_d, reg_we_d, wb_sel_mem_d, dmem_req_d, dmem_we_d;
    logic [ALU_OP_W-1:0] alu_op_d;
    logic                alu_src_imm_d;

    logic [PC_W-1:0]     pc_plus4_c, b_target_c, cbz_target_c;

    legv8_opdecode u_opdecode (
        .opcode        (opcode),
        .instr_class_c (dec_cls_c),
        .alu_op_c      (dec_alu_c)
    );

    // Branch offsets: sign-extend to PC_W first, then scale to bytes
    assign pc_plus4_c   = pc + PC_W'(4);
    assign b_target_c   = pc + (PC_W'($signed(ir[25:0])) << 2);
    assign cbz_target_c = pc + (PC_W'($signed(ir[23:5])) << 2);

    assign imem_addr = pc;

    // Next-state, datapath-register and registered-output logic
    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        pc_d          = pc;
        ir_d          = ir;
        halted_d      = halted;
        illegal_d     = illegal;
        alu_op_d      = alu_op;
        alu_src_imm_d = alu_src_imm;

        case (state_q)
            // imem_valid only counts once the request is actually visible
            ST_FETCH: begin
                if (imem_req && imem_valid) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                cls_d         = dec_cls_c;
                alu_op_d      = dec_alu_c;
                alu_src_imm_d = (dec_cls_c == CLS_LD) || (dec_cls_c == CLS_ST);
                state_d       = ST_EXEC;
            end
            ST_EXEC: begin
                case (cls_q)
                    CLS_R:          state_d = ST_WB;
                    CLS_LD, CLS_ST: state_d = ST_MEM;
                    CLS_B: begin
                        pc_d    = b_target_c;
                        state_d = ST_FETCH;
                    end
                    CLS_CBZ: begin
                        pc_d    = alu_zero ? cbz_target_c : pc_plus4_c;
                        state_d = ST_FETCH;
                    end
                    CLS_HALT: begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    if (cls_q == CLS_ST) begin
                        pc_d    = pc_plus4_c;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                pc_d    = pc_plus4_c;
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        // Strobes are a function of the state being entered, so they
        // line up with the registered state and have no input paths
        imem_req_d   = (state_d == ST_FETCH);
        dmem_req_d   = (state_d == ST_MEM);
        dmem_we_d    = (state_d == ST_MEM) && (cls_d == CLS_ST);
        reg_we_d     = (state_d == ST_WB);
        wb_sel_mem_d = (state_d == ST_WB) && (cls_d == CLS_LD);
        if ((state_d == ST_FETCH) || (state_d == ST_HALT)) begin
            alu_op_d      = ALU_ADD;
            alu_src_imm_d = 1'b0;
        end
    end

    // State, PC, IR and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            cls_q       <= CLS_R;
            pc          <= '0;
            ir          <= '0;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            imem_req    <= 1'b0;
            reg_we      <= 1'b0;
            wb_sel_mem  <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            alu_op      <= ALU_ADD;
            alu_src_imm <= 1'b0;
        end else begin
            state_q     <= state_d;
            cls_q       <= cls_d;
            pc          <= pc_d;
            ir          <= ir_d;
            halted      <= halted_d;
            illegal     <= illegal_d;
            imem_req    <= imem_req_d;
            reg_we      <= reg_we_d;
            wb_sel_mem  <= wb_sel_mem_d;
            dmem_req    <= dmem_req_d;
            dmem_we     <= dmem_we_d;
            alu_op      <= alu_op_d;
            alu_src_imm <= alu_src_imm_d;
        end
    end

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// Directed self-checking bench for legv8_mc_ctrl; opcode is taken from
// ir[31:21] the way the field parser would deliver it.
module tb_legv8_mc_ctrl;

    localparam logic [31:0] I_ADD   = 32'h8B02_0020; // ADD X0,X1,X2
    localparam logic [31:0] I_LDUR  = 32'hF840_8023; // LDUR X3,[X1,#8]
    localparam logic [31:0] I_STUR  = 32'hF800_0020; // STUR X0,[X1,#0]
    localparam logic [31:0] I_B_P2  = 32'h1400_0002; // B +2
    localparam logic [31:0] I_B_M6  = 32'h17FF_FFFA; // B -6
    localparam logic [31:0] I_B_P1  = 32'h1400_0001; // B +1
    localparam logic [31:0] I_CBZ   = 32'hB4FF_FFC0; // CBZ X0,-2
    localparam logic [31:0] I_UNDEF = 32'h0000_0000;
    localparam logic [31:0] I_HALT  = 32'hFFE0_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [10:0] opcode;
    logic        alu_zero;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_we;
    logic        wb_sel_mem;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic [31:0] pc;
    logic        halted;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    int we_cnt;
    int req_cnt;
    int dreq_cnt;

    always #5 clk = ~clk;

    assign opcode = ir[31:21];

    legv8_mc_ctrl #(.PC_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .opcode      (opcode),
        .alu_zero    (alu_zero),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .reg_we      (reg_we),
        .wb_sel_mem  (wb_sel_mem),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_ready  (dmem_ready),
        .pc          (pc),
        .halted      (halted),
        .illegal     (illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (reg_we)   we_cnt++;
        if (imem_req) req_cnt++;
    endtask

    // Fetch from FETCH state with a number of wait cycles; ends in DECODE
    task automatic fetch(input logic [31:0] instr, input int waits, input logic [31:0] addr);
        check("fetch_req", 32'(imem_req), 32'd1);
        for (int i = 0; i < waits; i++) begin
            imem_rdata = 32'hDEAD_BEEF;
            step();
            check("fetch_wait_addr", imem_addr, addr);
            check("fetch_wait_req", 32'(imem_req), 32'd1);
        end
        check("fetch_addr", imem_addr, addr);
        imem_valid = 1'b1;
        imem_rdata = instr;
        step();
        imem_valid = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("ir_load", ir, instr);
        check("decode_req_low", 32'(imem_req), 32'd0);
    endtask

    // Branch-class instruction: FETCH, DECODE, EXEC, back to FETCH
    task automatic run_branch(input logic [31:0] instr, input logic zero, input logic [31:0] addr,
                              input logic [31:0] exp_pc, input string tag);
        cyc = 1;
        fetch(instr, 0, addr);
        alu_zero = zero;
        step();
        step();
        alu_zero = 1'b0;
        check(tag, pc, exp_pc);
        check("branch_cycles", 32'(cyc), 32'd4);
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        alu_zero   = 1'b0;
        dmem_ready = 1'b0;
        cyc        = 0;
        we_cnt     = 0;
        req_cnt    = 0;
        dreq_cnt   = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_strobes", {28'h0, reg_we, dmem_req, dmem_we, wb_sel_mem}, 32'h0);
        check("rst_alu", {29'h0, alu_op, alu_src_imm}, 32'h0);
        check("rst_status", {30'h0, halted, illegal}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ADD, zero-wait: reg_we in cycle 4, pc=4 afterwards
        cyc = 1;
        fetch(I_ADD, 0, 32'h0);
        step();
        check("add_exec_alu", 32'(alu_op), 32'd0);
        check("add_exec_we", 32'(reg_we), 32'd0);
        step();
        check("add_wb_we", 32'(reg_we), 32'd1);
        check("add_wb_cycle", 32'(cyc), 32'd4);
        check("add_wb_alu", 32'(alu_op), 32'd0);
        check("add_wb_sel", 32'(wb_sel_mem), 32'd0);
        check("add_wb_pc_hold", pc, 32'h0);
        step();
        check("add_pc", pc, 32'h4);
        check("add_we_drop", 32'(reg_we), 32'd0);

        // LDUR with 2 fetch waits and 3 memory waits: 10 cycles total
        cyc = 1;
        fetch(I_LDUR, 2, 32'h4);
        step();
        check("ld_exec_imm", 32'(alu_src_imm), 32'd1);
        check("ld_exec_alu", 32'(alu_op), 32'd0);
        check("ld_exec_dreq", 32'(dmem_req), 32'd0);
        step();
        dreq_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (dmem_req) dreq_cnt++;
            check("ld_mem_we", 32'(dmem_we), 32'd0);
            check("ld_mem_imm_hold", 32'(alu_src_imm), 32'd1);
            dmem_ready = (i == 3);
            step();
            dmem_ready = 1'b0;
        end
        check("ld_dreq_cycles", 32'(dreq_cnt), 32'd4);
        check("ld_wb_dreq", 32'(dmem_req), 32'd0);
        check("ld_wb_we", 32'(reg_we), 32'd1);
        check("ld_wb_sel", 32'(wb_sel_mem), 32'd1);
        check("ld_total_cycles", 32'(cyc), 32'd10);
        step();
        check("ld_pc", pc, 32'h8);

        // Branches: reach pc=16, CBZ taken/not-taken, then wrap through all-ones
        we_cnt = 0;
        run_branch(I_B_P2, 1'b0, 32'h8,  32'h10, "b_fwd_pc");
        run_branch(I_CBZ,  1'b1, 32'h10, 32'h8,  "cbz_taken_pc");
        run_branch(I_B_P2, 1'b0, 32'h8,  32'h10, "b_fwd2_pc");
        run_branch(I_CBZ,  1'b0, 32'h10, 32'h14, "cbz_not_taken_pc");
        check("branch_no_reg_we", 32'(we_cnt), 32'd0);
        run_branch(I_B_M6, 1'b0, 32'h14, 32'hFFFF_FFFC, "b_back_pc");
        run_branch(I_B_P1, 1'b0, 32'hFFFF_FFFC, 32'h0, "b_wrap_pc");

        // STUR zero-wait, then an undefined opcode
        cyc = 1;
        fetch(I_STUR, 0, 32'h0);
        step();
        check("st_exec_imm", 32'(alu_src_imm), 32'd1);
        step();
        check("st_mem_req", 32'(dmem_req), 32'd1);
        check("st_mem_we", 32'(dmem_we), 32'd1);
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        check("st_pc", pc, 32'h4);
        check("st_cycles", 32'(cyc), 32'd5);
        check("st_dreq_drop", 32'(dmem_req), 32'd0);

        fetch(I_UNDEF, 0, 32'h4);
        step();
        step();
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_not_halted", 32'(halted), 32'd0);
        req_cnt = 0;
        imem_valid = 1'b1;
        dmem_ready = 1'b1;
        repeat (4) step();
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        check("ill_no_fetch", 32'(req_cnt), 32'd0);
        check("ill_pc_frozen", pc, 32'h4);
        check("ill_ir_frozen", ir, I_UNDEF);

        // Reset pulsed during MEM of a STUR at pc=4
        rst_n = 1'b0;
        #1;
        check("rst2_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        fetch(I_ADD, 0, 32'h0);
        step();
        step();
        step();
        check("rst2_add_pc", pc, 32'h4);
        fetch(I_STUR, 0, 32'h4);
        step();
        step();
        check("rst2_mem_req", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst2_async_dreq", 32'(dmem_req), 32'd0);
        check("rst2_async_dwe", 32'(dmem_we), 32'd0);
        check("rst2_async_pc", pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
        check("rst2_late_ready_dreq", 32'(dmem_req), 32'd0);
        check("rst2_late_ready_pc", pc, 32'h0);
        check("rst2_resume_req", 32'(imem_req), 32'd1);
        check("rst2_resume_addr", imem_addr, 32'h0);
        step();
        check("rst2_resume_pc", pc, 32'h0);

        // HALT instruction at 0
        fetch(I_HALT, 0, 32'h0);
        step();
        step();
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_no_ill", 32'(illegal), 32'd0);
        check("halt_no_req", 32'(imem_req), 32'd0);
        check("halt_pc", pc, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
